// File: rtl/ctrl_seq_if.sv
// Control-sequencer bundle: decoded IR fields and mem_ack in, bus strobes and status out.
// master = sequencer side, slave = datapath/memory side.
interface ctrl_seq_if;
  logic [3:0] opcode;
  logic       S;
  logic [1:0] shift;
  logic [2:0] rd1;
  logic [2:0] rd2;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic       mem_ack;

  logic       pc_out;
  logic       pc_in;
  logic       pc_inc;
  logic       mar_in;
  logic       mdr_in;
  logic       mdr_out;
  logic       ir_in;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] reg_in;
  logic [7:0] reg_out;
  logic       alu_a_in;
  logic [2:0] alu_op;
  logic [1:0] alu_shift;
  logic       z_in;
  logic       z_out;
  logic       flags_en;
  logic       halted;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, S, shift, rd1, rd2, rs1, rs2, mem_ack,
    output pc_out, pc_in, pc_inc, mar_in, mdr_in, mdr_out, ir_in,
           mem_rd, mem_wr, reg_in, reg_out, alu_a_in, alu_op, alu_shift,
           z_in, z_out, flags_en, halted, illegal, state_dbg
  );

  modport slave (
    output opcode, S, shift, rd1, rd2, rs1, rs2, mem_ack,
    input  pc_out, pc_in, pc_inc, mar_in, mdr_in, mdr_out, ir_in,
           mem_rd, mem_wr, reg_in, reg_out, alu_a_in, alu_op, alu_shift,
           z_in, z_out, flags_en, halted, illegal, state_dbg
  );
endinterface

// File: rtl/ctrl_seq.sv
// Hardwired Moore control sequencer for the 16-bit single-bus CPU: fetch/decode/execute strobes.
// Strobes decode from the state register plus IR fields; reset high blanks every output that cycle.
module ctrl_seq #(
  parameter int WAIT_TIMEOUT  = 0,
  parameter bit ILLEGAL_HALTS = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  ctrl_seq_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH0 = 4'd0,
    FETCH1 = 4'd1,
    FETCH2 = 4'd2,
    DECODE = 4'd3,
    ALU1   = 4'd4,
    ALU2   = 4'd5,
    ALU3   = 4'd6,
    MEM0   = 4'd7,
    MEM1   = 4'd8,
    MEM2   = 4'd9,
    ST1    = 4'd10,
    JMP_S  = 4'd11,
    HALT_S = 4'd15
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state;
  logic [31:0] wait_cnt;

  logic is_alu;
  logic is_wait;
  logic timeout;

  assign is_alu  = (bus.opcode >= OP_ADD) && (bus.opcode <= OP_MOV);
  assign is_wait = (state == FETCH1) || (state == MEM1);
  // Ack on the expiring cycle wins: timeout only fires when ack is absent.
  assign timeout = (WAIT_TIMEOUT > 0) && is_wait && !bus.mem_ack &&
                   (wait_cnt == 32'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH0;
      wait_cnt <= 32'd0;
    end else begin
      wait_cnt <= (is_wait && !bus.mem_ack) ? wait_cnt + 32'd1 : 32'd0;
      case (state)
        FETCH0: state <= FETCH1;
        FETCH1: begin
          if (bus.mem_ack)  state <= FETCH2;
          else if (timeout) state <= FETCH0;
        end
        FETCH2: state <= DECODE;
        DECODE: begin
          if (is_alu) state <= ALU1;
          else begin
            case (bus.opcode)
              OP_LDI, OP_LD, OP_ST: state <= MEM0;
              OP_JMP:               state <= JMP_S;
              OP_NOP:               state <= FETCH0;
              OP_HALT:              state <= HALT_S;
              default:              state <= ILLEGAL_HALTS ? HALT_S : FETCH0;
            endcase
          end
        end
        ALU1:   state <= ALU2;
        ALU2:   state <= ALU3;
        ALU3:   state <= FETCH0;
        MEM0:   state <= (bus.opcode == OP_ST) ? ST1 : MEM1;
        ST1:    state <= MEM1;
        MEM1: begin
          if (bus.mem_ack)  state <= (bus.opcode == OP_ST) ? FETCH0 : MEM2;
          else if (timeout) state <= FETCH0;
        end
        MEM2:   state <= FETCH0;
        JMP_S:  state <= FETCH0;
        HALT_S: state <= HALT_S;
        default: state <= FETCH0;
      endcase
    end
  end

  always_comb begin
    bus.pc_out    = 1'b0;
    bus.pc_in     = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.mar_in    = 1'b0;
    bus.mdr_in    = 1'b0;
    bus.mdr_out   = 1'b0;
    bus.ir_in     = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.reg_in    = 8'h00;
    bus.reg_out   = 8'h00;
    bus.alu_a_in  = 1'b0;
    bus.alu_op    = 3'd0;
    bus.alu_shift = 2'd0;
    bus.z_in      = 1'b0;
    bus.z_out     = 1'b0;
    bus.flags_en  = 1'b0;
    bus.halted    = 1'b0;
    bus.illegal   = 1'b0;
    bus.state_dbg = 4'd0;
    if (!reset) begin
      bus.state_dbg = state;
      case (state)
        FETCH0: begin
          bus.pc_out = 1'b1;
          bus.mar_in = 1'b1;
        end
        FETCH1: begin
          bus.mem_rd  = 1'b1;
          bus.mdr_in  = 1'b1;
          bus.illegal = timeout;
        end
        FETCH2: begin
          bus.mdr_out = 1'b1;
          bus.ir_in   = 1'b1;
          bus.pc_inc  = 1'b1;
        end
        DECODE: begin
          bus.illegal = !is_alu && (bus.opcode > OP_JMP) && (bus.opcode != OP_HALT);
        end
        ALU1: begin
          bus.reg_out  = 8'b1 << bus.rs1;
          bus.alu_a_in = 1'b1;
        end
        ALU2: begin
          case (bus.opcode)
            OP_ADD:  bus.alu_op = 3'd0;
            OP_SUB:  bus.alu_op = 3'd1;
            OP_AND:  bus.alu_op = 3'd2;
            OP_OR:   bus.alu_op = 3'd3;
            default: bus.alu_op = 3'd4;
          endcase
          bus.alu_shift = bus.shift;
          bus.z_in      = 1'b1;
          bus.flags_en  = bus.S;
          if (bus.opcode != OP_MOV) bus.reg_out = 8'b1 << bus.rs2;
        end
        ALU3: begin
          bus.z_out  = 1'b1;
          bus.reg_in = 8'b1 << bus.rd1;
        end
        MEM0: begin
          if (bus.opcode == OP_LDI) bus.pc_out  = 1'b1;
          else                      bus.reg_out = 8'b1 << bus.rs1;
          bus.mar_in = 1'b1;
        end
        ST1: begin
          bus.reg_out = 8'b1 << bus.rs2;
          bus.mdr_in  = 1'b1;
        end
        MEM1: begin
          if (bus.opcode == OP_ST) begin
            bus.mem_wr = 1'b1;
          end else begin
            bus.mem_rd = 1'b1;
            bus.mdr_in = 1'b1;
          end
          bus.illegal = timeout;
        end
        MEM2: begin
          bus.mdr_out = 1'b1;
          if (bus.opcode == OP_LDI) begin
            bus.reg_in = 8'b1 << bus.rd2;
            bus.pc_inc = 1'b1;
          end else begin
            bus.reg_in = 8'b1 << bus.rd1;
          end
        end
        JMP_S: begin
          bus.reg_out = 8'b1 << bus.rs1;
          bus.pc_in   = 1'b1;
        end
        HALT_S: bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed per-cycle check of ctrl_seq strobes against hand-computed vectors.
module tb_ctrl_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  ctrl_seq_if bus ();

  ctrl_seq #(.WAIT_TIMEOUT(4), .ILLEGAL_HALTS(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] F_PC_OUT  = 15'h4000;
  localparam logic [14:0] F_PC_IN   = 15'h2000;
  localparam logic [14:0] F_PC_INC  = 15'h1000;
  localparam logic [14:0] F_MAR_IN  = 15'h0800;
  localparam logic [14:0] F_MDR_IN  = 15'h0400;
  localparam logic [14:0] F_MDR_OUT = 15'h0200;
  localparam logic [14:0] F_IR_IN   = 15'h0100;
  localparam logic [14:0] F_MEM_RD  = 15'h0080;
  localparam logic [14:0] F_MEM_WR  = 15'h0040;
  localparam logic [14:0] F_ALU_A   = 15'h0020;
  localparam logic [14:0] F_Z_IN    = 15'h0010;
  localparam logic [14:0] F_Z_OUT   = 15'h0008;
  localparam logic [14:0] F_FLAGS   = 15'h0004;
  localparam logic [14:0] F_HALT    = 15'h0002;
  localparam logic [14:0] F_ILL     = 15'h0001;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {state, alu_op, alu_shift, reg_in, reg_out, single-bit strobes}
  function automatic logic [39:0] snap();
    return {bus.state_dbg, bus.alu_op, bus.alu_shift, bus.reg_in, bus.reg_out,
            bus.pc_out, bus.pc_in, bus.pc_inc, bus.mar_in, bus.mdr_in, bus.mdr_out,
            bus.ir_in, bus.mem_rd, bus.mem_wr, bus.alu_a_in, bus.z_in, bus.z_out,
            bus.flags_en, bus.halted, bus.illegal};
  endfunction

  function automatic logic [39:0] ex(input logic [3:0] st, input logic [14:0] fl,
                                     input logic [7:0] ri = 8'h00, input logic [7:0] ro = 8'h00,
                                     input logic [2:0] op = 3'd0, input logic [1:0] sh = 2'd0);
    return {st, op, sh, ri, ro, fl};
  endfunction

  always @(negedge clk) begin
    chk("bus_single_driver",
        40'($countones({bus.pc_out, bus.mdr_out, bus.z_out, bus.reg_out}) <= 1), 40'd1);
  end

  task automatic cyc(input string tag, input logic [39:0] e);
    @(negedge clk);
    chk(tag, snap(), e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [15:0] ir);
    bus.opcode = ir[15:12];
    bus.S      = ir[11];
    bus.shift  = ir[10:9];
    bus.rd2    = ir[11:9];
    bus.rd1    = ir[8:6];
    bus.rs1    = ir[5:3];
    bus.rs2    = ir[2:0];
  endtask

  task automatic fetch3(input string tag, input logic [15:0] ir);
    set_ir(ir);
    bus.mem_ack = 1'b1;
    cyc({tag, "_f0"}, ex(4'd0, F_PC_OUT | F_MAR_IN));
    cyc({tag, "_f1"}, ex(4'd1, F_MEM_RD | F_MDR_IN));
    cyc({tag, "_f2"}, ex(4'd2, F_MDR_OUT | F_IR_IN | F_PC_INC));
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_ack = 1'b0;
    set_ir(16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc("reset_outputs", 40'd0);
    reset = 1'b0;

    // ADD r3 = r2 + r1, S=1
    fetch3("add", 16'h18D1);
    cyc("add_dec",  ex(4'd3, 15'h0));
    cyc("add_alu1", ex(4'd4, F_ALU_A, 8'h00, 8'h04));
    cyc("add_alu2", ex(4'd5, F_Z_IN | F_FLAGS, 8'h00, 8'h02, 3'd0, 2'd0));
    cyc("add_alu3", ex(4'd6, F_Z_OUT, 8'h08, 8'h00));

    // SUB r7 = r0 - r6, shift 1, no flags
    fetch3("sub", 16'h23C6);
    cyc("sub_dec",  ex(4'd3, 15'h0));
    cyc("sub_alu1", ex(4'd4, F_ALU_A, 8'h00, 8'h01));
    cyc("sub_alu2", ex(4'd5, F_Z_IN, 8'h00, 8'h40, 3'd1, 2'd1));
    cyc("sub_alu3", ex(4'd6, F_Z_OUT, 8'h80, 8'h00));

    // MOV r2 = r5, shift 2: no second operand on the bus
    fetch3("mov", 16'h54A8);
    cyc("mov_dec",  ex(4'd3, 15'h0));
    cyc("mov_alu1", ex(4'd4, F_ALU_A, 8'h00, 8'h20));
    cyc("mov_alu2", ex(4'd5, F_Z_IN, 8'h00, 8'h00, 3'd4, 2'd2));
    cyc("mov_alu3", ex(4'd6, F_Z_OUT, 8'h04, 8'h00));

    // LD r5 = mem[r6], ack on third wait cycle
    fetch3("ld", 16'h7170);
    cyc("ld_dec",  ex(4'd3, 15'h0));
    bus.mem_ack = 1'b0;
    cyc("ld_mem0", ex(4'd7, F_MAR_IN, 8'h00, 8'h40));
    cyc("ld_w1",   ex(4'd8, F_MEM_RD | F_MDR_IN));
    cyc("ld_w2",   ex(4'd8, F_MEM_RD | F_MDR_IN));
    bus.mem_ack = 1'b1;
    cyc("ld_w3",   ex(4'd8, F_MEM_RD | F_MDR_IN));
    cyc("ld_mem2", ex(4'd9, F_MDR_OUT, 8'h20, 8'h00));

    // ST mem[r1] = r7, one extra wait cycle
    fetch3("st", 16'h800F);
    cyc("st_dec",  ex(4'd3, 15'h0));
    bus.mem_ack = 1'b0;
    cyc("st_mem0", ex(4'd7, F_MAR_IN, 8'h00, 8'h02));
    cyc("st_st1",  ex(4'd10, F_MDR_IN, 8'h00, 8'h80));
    cyc("st_w1",   ex(4'd8, F_MEM_WR));
    bus.mem_ack = 1'b1;
    cyc("st_w2",   ex(4'd8, F_MEM_WR));

    // LDI r4 = next word
    fetch3("ldi", 16'h6800);
    cyc("ldi_dec",  ex(4'd3, 15'h0));
    cyc("ldi_mem0", ex(4'd7, F_PC_OUT | F_MAR_IN));
    cyc("ldi_mem1", ex(4'd8, F_MEM_RD | F_MDR_IN));
    cyc("ldi_mem2", ex(4'd9, F_MDR_OUT | F_PC_INC, 8'h10, 8'h00));

    // JMP r3
    fetch3("jmp", 16'h9018);
    cyc("jmp_dec", ex(4'd3, 15'h0));
    cyc("jmp_exe", ex(4'd11, F_PC_IN, 8'h00, 8'h08));

    // undefined opcode refetches
    fetch3("ill", 16'hB000);
    cyc("ill_dec", ex(4'd3, F_ILL));

    fetch3("nop", 16'h0000);
    cyc("nop_dec", ex(4'd3, 15'h0));

    // reset during fetch wait
    bus.mem_ack = 1'b0;
    cyc("rw_f0", ex(4'd0, F_PC_OUT | F_MAR_IN));
    cyc("rw_f1", ex(4'd1, F_MEM_RD | F_MDR_IN));
    reset = 1'b1;
    cyc("rw_reset", 40'd0);
    reset = 1'b0;
    cyc("rw_f0_after", ex(4'd0, F_PC_OUT | F_MAR_IN));

    // timeout on the 4th wait cycle
    for (int i = 1; i <= 3; i++) cyc("to_wait", ex(4'd1, F_MEM_RD | F_MDR_IN));
    cyc("to_fire", ex(4'd1, F_MEM_RD | F_MDR_IN | F_ILL));
    cyc("to_refetch", ex(4'd0, F_PC_OUT | F_MAR_IN));

    // ack on the would-be timeout cycle wins
    for (int i = 1; i <= 3; i++) cyc("tp_wait", ex(4'd1, F_MEM_RD | F_MDR_IN));
    bus.mem_ack = 1'b1;
    cyc("tp_ack", ex(4'd1, F_MEM_RD | F_MDR_IN));
    cyc("tp_f2",  ex(4'd2, F_MDR_OUT | F_IR_IN | F_PC_INC));
    cyc("tp_dec", ex(4'd3, 15'h0));

    // HALT holds until reset
    fetch3("halt", 16'hF000);
    cyc("halt_dec", ex(4'd3, 15'h0));
    for (int i = 0; i < 20; i++) cyc("halt_hold", ex(4'd15, F_HALT));
    reset = 1'b1;
    cyc("halt_reset", 40'd0);
    reset = 1'b0;
    cyc("halt_f0", ex(4'd0, F_PC_OUT | F_MAR_IN));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
